divisor_sequencial: RTL and testbench

DIVISOR_SEQUENCIAL -- requirements
Module: divisor_sequencial

---
 rtl/divisor_sequencial_pkg.sv | 21 ++
 rtl/divisor_sequencial_estagio.sv | 21 ++
 rtl/divisor_sequencial.sv | 115 +++++++++++
 tb/tb_divisor_sequencial.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/divisor_sequencial_pkg.sv
// Shared widths, state encoding and zero-divisor result constants
// for the 8-by-4 restoring sequential divider.
package divisor_sequencial_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int ITER_COUNT = 8;
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int CNT_W      = 4;

    localparam logic [CNT_W-1:0]      LAST_ITER          = CNT_W'(ITER_COUNT - 1);
    localparam logic [DIVIDEND_W-1:0] ZERO_DIV_QUOTIENT  = 8'hFF;
    localparam logic [DIVISOR_W-1:0]  ZERO_DIV_REMAINDER = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divisor_sequencial_estagio.sv
// One restoring-division step: compare the shifted partial remainder with
// the divisor and subtract when it fits.
module divisor_estagio
    import divisor_sequencial_pkg::*;
(
    input  logic [REM_W-1:0]     partial,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     next_rem,
    output logic                 q_bit
);

    logic [REM_W-1:0] divisor_ext;

    assign divisor_ext = {1'b0, divisor};

    always_comb begin
        q_bit    = (partial >= divisor_ext);
        next_rem = q_bit ? (partial - divisor_ext) : partial;
    end

endmodule

// File: rtl/divisor_sequencial.sv
// Sequential 8-bit / 4-bit unsigned divider: one restoring step per CALC
// cycle, MSB first, with a single-cycle DONE pulse carrying the result.
module divisor_sequencial
    import divisor_sequencial_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    state_t state, next_state;

    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVIDEND_W-1:0] quo_sh;
    logic [DIVISOR_W-1:0]  dvs_reg;
    logic [REM_W-1:0]      rem;
    logic [CNT_W-1:0]      cnt;

    logic [REM_W-1:0]      partial;
    logic [REM_W-1:0]      step_rem;
    logic                  step_q;
    logic [DIVIDEND_W-1:0] quo_next;

    // Bring down the next dividend bit; the truncating cast drops the
    // partial remainder's top bit, which is always zero after a step.
    assign partial  = REM_W'({rem, dvd_sh[DIVIDEND_W-1]});
    assign quo_next = DIVIDEND_W'({quo_sh, step_q});

    divisor_estagio u_estagio (
        .partial  (partial),
        .divisor  (dvs_reg),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_ITER) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sh      <= '0;
            quo_sh      <= '0;
            dvs_reg     <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dvd_sh  <= dividend;
                            dvs_reg <= divisor;
                            quo_sh  <= '0;
                            rem     <= '0;
                            cnt     <= '0;
                        end else begin
                            quotient    <= ZERO_DIV_QUOTIENT;
                            remainder   <= ZERO_DIV_REMAINDER;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem    <= step_rem;
                    dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], 1'b0};
                    quo_sh <= quo_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        quotient    <= quo_next;
                        remainder   <= step_rem[DIVISOR_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Randomised and directed bench for divisor_sequencial, compared against
// plain integer division.
module tb_divisor_sequencial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] prev_q   = '0;
    logic [3:0] prev_r   = '0;
    logic       prev_dbz = 1'b0;

    divisor_sequencial dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation at a negedge, follow it to completion and return
    // at the negedge of the idle cycle after DONE.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit repulse,
                          output logic [7:0] got_q, output logic [3:0] got_r);
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_dbz;
        int         exp_lat;
        bit         seen;
        if (b == 0) begin
            exp_q = 8'hFF; exp_r = 4'hF; exp_dbz = 1'b1; exp_lat = 0;
        end else begin
            exp_q = 8'(a / b); exp_r = 4'(a % b); exp_dbz = 1'b0; exp_lat = 8;
        end
        got_q = 'x;
        got_r = 'x;
        seen  = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        for (int cyc = 0; cyc < 16 && !seen; cyc++) begin
            if (done) begin
                seen  = 1;
                got_q = quotient;
                got_r = remainder;
                check("latency", cyc, exp_lat);
                check("quotient", quotient, exp_q);
                check("remainder", remainder, exp_r);
                check("div_by_zero", div_by_zero, exp_dbz);
                check("busy_in_done", busy, 1);
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("idle_after_done", busy, 0);
                check("result_held", quotient, exp_q);
            end else begin
                check("busy_calc", busy, 1);
                check("hold_quotient", quotient, prev_q);
                check("hold_remainder", remainder, prev_r);
                check("hold_dbz", div_by_zero, prev_dbz);
                if (repulse && cyc == 3) begin
                    start    = 1'b1;
                    dividend = 8'd37;
                    divisor  = 4'd2;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        if (repulse) begin
            for (int i = 0; i < 12; i++) begin
                check("no_extra_done", done, 0);
                @(negedge clk);
            end
        end
        prev_q   = exp_q;
        prev_r   = exp_r;
        prev_dbz = exp_dbz;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        logic [3:0] r;
        logic [7:0] ra;
        logic [3:0] rb;

        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        // Accepted on the very first edge after reset release.
        run_op(8'd200, 4'd13, 0, q, r);
        run_op(8'd7,   4'd9,  0, q, r);
        run_op(8'd225, 4'd15, 0, q, r);
        run_op(8'd100, 4'd0,  0, q, r);
        run_op(8'd200, 4'd13, 1, q, r);
        run_op(8'd0,   4'd0,  0, q, r);
        run_op(8'd255, 4'd1,  0, q, r);
        run_op(8'd255, 4'd15, 0, q, r);
        run_op(8'd14,  4'd3,  0, q, r);

        // Abort during the 4th CALC cycle.
        dividend = 8'd200;
        divisor  = 4'd13;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            check("abort_no_done", done, 0);
        end
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;
        run_op(8'd255, 4'd1, 0, q, r);
        check("post_abort_q", q, 255);
        check("post_abort_r", r, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a * b), 4'(b), 0, q, r);
                check("sweep_q", q, a);
                check("sweep_r", r, 0);
            end
        end

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            run_op(ra, rb, ($urandom_range(0, 9) == 0), q, r);
            if (rb != 0) begin
                check("identity", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
                check("rem_lt_div", (r < rb), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
